// File: rtl/sdram_loader_if.sv
// sdram_bus: toggle req/ack channel between a bus initiator
// and one port of the sdram controller.
interface sdram_bus #(
  parameter int ADDR_BITS = 23
);
  logic                 req;
  logic                 ack;
  logic                 we;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [15:0]          data_read;

  modport initiator (
    output req, we, address, data_write,
    input  ack, data_read
  );

  modport target (
    input  req, we, address, data_write,
    output ack, data_read
  );
endinterface

// File: rtl/sdram_loader.sv
// sdram_loader: packs a byte stream little-endian into 16-bit words
// and writes them to consecutive SDRAM word addresses via sdram_bus.
module sdram_loader #(
  parameter int ADDR_BITS = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  input  logic                 byte_last,
  output logic                 byte_ready,
  output logic                 busy,
  output logic                 done,
  sdram_bus.initiator          bus
);

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    LOW,
    HIGH,
    WRITE
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] address_q;
  logic [15:0]          data_q;
  logic                 req_q;
  logic                 we_q;
  logic                 ack_q;
  logic                 last_q;
  logic                 issue;

  assign bus.req        = req_q;
  assign bus.we         = we_q;
  assign bus.address    = address_q;
  assign bus.data_write = data_q;

  // A word is complete on a high byte, or on a final low byte.
  assign issue = byte_valid &&
                 ((state == HIGH) ||
                  (state == LOW && byte_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      addr       <= '0;
      address_q  <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      last_q     <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ack_q <= bus.ack;
      done  <= 1'b0;
      unique case (state)
        SYNC: begin
          // Drop any request lost across reset.
          req_q <= bus.ack;
          state <= IDLE;
        end
        IDLE: begin
          if (start) begin
            addr       <= base_addr;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
            last_q     <= 1'b0;
            state      <= LOW;
          end
        end
        LOW: begin
          if (byte_valid) begin
            if (byte_last) begin
              data_q <= {8'h00, byte_data};
              last_q <= 1'b1;
            end else begin
              data_q[7:0] <= byte_data;
              state       <= HIGH;
            end
          end
        end
        HIGH: begin
          if (byte_valid) begin
            data_q[15:8] <= byte_data;
            last_q       <= byte_last;
          end
        end
        WRITE: begin
          if (ack_q == req_q) begin
            addr <= addr + 1'b1;
            if (last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              byte_ready <= 1'b1;
              state      <= LOW;
            end
          end
        end
        default: state <= SYNC;
      endcase
      if (issue) begin
        we_q       <= 1'b1;
        address_q  <= addr;
        req_q      <= ~req_q;
        byte_ready <= 1'b0;
        state      <= WRITE;
      end
    end
  end

endmodule

// File: tb/tb_sdram_loader.sv
// tb_sdram_loader: directed scenarios against a toggle-handshake
// responder, with a bus monitor logging every issued write.
module tb_sdram_loader;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_last = 1'b0;
  logic          byte_ready;
  logic          busy;
  logic          done;

  sdram_bus #(.ADDR_BITS(AW)) bus ();

  assign bus.data_read = '0;

  sdram_loader #(.ADDR_BITS(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder: acks a pending req after `delay` cycles; kicks
  // force a lone ack toggle (a controller finishing a stale write).
  bit resp_en = 1'b0;
  bit resp_rst = 1'b1;
  int delay = 0;
  int kick_cnt = 0;
  int kick_done = 0;
  int cnt = 0;

  always @(posedge clk) begin
    if (resp_rst) begin
      bus.ack <= 1'b0;
      cnt     <= 0;
    end else if (kick_cnt != kick_done) begin
      bus.ack   <= ~bus.ack;
      kick_done <= kick_done + 1;
    end else if (resp_en && bus.req != bus.ack) begin
      if (cnt >= delay) begin
        bus.ack <= bus.req;
        cnt     <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  logic [AW-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];
  logic          wr_we[$];
  logic          prev_req = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [15:0]   cur_data = '0;
  logic          cur_we = 1'b0;
  int            toggles = 0;
  int            dones = 0;
  int            unstable = 0;
  int            ready_in_wait = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = bus.req;
      cur_addr = bus.address;
      cur_data = bus.data_write;
      cur_we   = bus.we;
    end else begin
      if (bus.req != prev_req) begin
        toggles++;
        wr_addr.push_back(bus.address);
        wr_data.push_back(bus.data_write);
        wr_we.push_back(bus.we);
        cur_addr = bus.address;
        cur_data = bus.data_write;
        cur_we   = bus.we;
        prev_req = bus.req;
      end else if (bus.req != bus.ack &&
                   (bus.address !== cur_addr ||
                    bus.data_write !== cur_data ||
                    bus.we !== cur_we)) begin
        unstable++;
      end
      if (bus.req != bus.ack && byte_ready) ready_in_wait++;
      if (done) dones++;
    end
  end

  task automatic clear_log();
    @(posedge clk);
    toggles = 0;
    dones = 0;
    unstable = 0;
    ready_in_wait = 0;
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk);
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_accept: busy=%b byte_ready=%b want 1 1",
               busy, byte_ready);
    end
  endtask

  task automatic send_bytes(input logic [7:0] bs[6], input int n);
    int wt;
    for (int i = 0; i < n; i++) begin
      byte_data  = bs[i];
      byte_valid = 1'b1;
      byte_last  = (i == n - 1);
      wt = 0;
      while (!byte_ready && wt < 200) begin
        @(negedge clk);
        wt++;
      end
      if (!byte_ready) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %0d not accepted", i);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done();
    int wt = 0;
    while (!done && wt < 300) begin
      @(negedge clk);
      wt++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b want 1", done);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done: busy=%b want 0", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width: done=%b want 0", done);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    resp_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done=%b want 000",
               {byte_ready, busy, done});
    end
    checks++;
    if ({bus.req, bus.we} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_we: %b want 00", {bus.req, bus.we});
    end
    checks++;
    if (bus.address !== '0 || bus.data_write !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want 0 0",
               bus.address, bus.data_write);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: ready=%b busy=%b want 0 0",
               byte_ready, busy);
    end
    checks++;
    if (bus.req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: req=%b want 0", bus.req);
    end
    byte_valid = 1'b0;
    resp_en = 1'b1;
  endtask

  task automatic test_basic();
    delay = 1;
    clear_log();
    do_start(23'h000010);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 4);
    wait_done();
    checks++;
    if (toggles !== 2 || dones !== 1) begin
      errors++;
      $display("FAIL basic_counts: toggles=%0d dones=%0d want 2 1",
               toggles, dones);
    end
    checks++;
    if ({wr_addr[0], wr_data[0], wr_we[0]} !== {23'h10, 16'h2211, 1'b1}) begin
      errors++;
      $display("FAIL basic_w0: addr=%h data=%h we=%b want 10 2211 1",
               wr_addr[0], wr_data[0], wr_we[0]);
    end
    checks++;
    if ({wr_addr[1], wr_data[1], wr_we[1]} !== {23'h11, 16'h4433, 1'b1}) begin
      errors++;
      $display("FAIL basic_w1: addr=%h data=%h we=%b want 11 4433 1",
               wr_addr[1], wr_data[1], wr_we[1]);
    end
  endtask

  task automatic test_odd_length();
    delay = 3;
    clear_log();
    do_start(23'h000100);
    send_bytes('{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    wait_done();
    checks++;
    if (toggles !== 1 || dones !== 1) begin
      errors++;
      $display("FAIL odd_counts: toggles=%0d dones=%0d want 1 1",
               toggles, dones);
    end
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {23'h100, 16'h00AB}) begin
      errors++;
      $display("FAIL odd_w0: addr=%h data=%h want 100 00ab",
               wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_wrap();
    delay = 0;
    clear_log();
    do_start(23'h7FFFFF);
    send_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00}, 4);
    wait_done();
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {23'h7FFFFF, 16'h0201}) begin
      errors++;
      $display("FAIL wrap_w0: addr=%h data=%h want 7fffff 0201",
               wr_addr[0], wr_data[0]);
    end
    checks++;
    if ({wr_addr[1], wr_data[1]} !== {23'h000000, 16'h0403}) begin
      errors++;
      $display("FAIL wrap_w1: addr=%h data=%h want 000000 0403",
               wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_backpressure();
    delay = 20;
    clear_log();
    do_start(23'h000400);
    send_bytes('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6}, 6);
    wait_done();
    checks++;
    if (toggles !== 3 || dones !== 1) begin
      errors++;
      $display("FAIL bp_counts: toggles=%0d dones=%0d want 3 1",
               toggles, dones);
    end
    checks++;
    if (ready_in_wait !== 0 || unstable !== 0) begin
      errors++;
      $display("FAIL bp_wait: ready_in_wait=%0d unstable=%0d want 0 0",
               ready_in_wait, unstable);
    end
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {23'h400, 16'hA2A1} ||
        {wr_addr[1], wr_data[1]} !== {23'h401, 16'hA4A3} ||
        {wr_addr[2], wr_data[2]} !== {23'h402, 16'hA6A5}) begin
      errors++;
      $display("FAIL bp_data: %h/%h %h/%h %h/%h want 400/a2a1 401/a4a3 402/a6a5",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1],
               wr_addr[2], wr_data[2]);
    end
  endtask

  task automatic test_start_ignored();
    delay = 2;
    clear_log();
    fork
      begin
        do_start(23'h000200);
        send_bytes('{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00, 8'h00}, 4);
      end
      begin
        repeat (4) @(negedge clk);
        base_addr = 23'h000300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || toggles !== 2 || dones !== 1) begin
      errors++;
      $display("FAIL mid_start: busy=%b toggles=%0d dones=%0d want 0 2 1",
               busy, toggles, dones);
    end
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {23'h200, 16'h6B5A} ||
        {wr_addr[1], wr_data[1]} !== {23'h201, 16'h8D7C}) begin
      errors++;
      $display("FAIL mid_start_data: %h/%h %h/%h want 200/6b5a 201/8d7c",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_in_write();
    resp_en = 1'b0;
    clear_log();
    do_start(23'h000040);
    send_bytes('{8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req !== 1'b1 || bus.ack !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending: req=%b ack=%b ready=%b want 1 0 0",
               bus.req, bus.ack, byte_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    kick_cnt++;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_write: req=%b busy=%b want 0 0", bus.req, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req !== 1'b1 || bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL realign: req=%b ack=%b want 1 1", bus.req, bus.ack);
    end
    resp_en = 1'b1;
    delay = 1;
    clear_log();
    do_start(23'h000020);
    send_bytes('{8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    wait_done();
    checks++;
    if (toggles !== 1 || dones !== 1) begin
      errors++;
      $display("FAIL post_rst_counts: toggles=%0d dones=%0d want 1 1",
               toggles, dones);
    end
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {23'h20, 16'h8877}) begin
      errors++;
      $display("FAIL post_rst_w0: addr=%h data=%h want 20 8877",
               wr_addr[0], wr_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_in_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_loader.md
# sdram_loader

Bus initiator that streams a byte sequence into SDRAM over one `sdram_bus` channel. It packs incoming bytes little-endian into 16-bit words and issues one toggle-handshake write per word at consecutive word addresses from a programmed base. It sits between the MCU/ROM-load byte source and channel 0 or 1 of the `sdram` controller, and is the requesting end of the `req`/`ack` protocol that `sdram` answers.

## Interface
- `ADDR_BITS`, 23, word-address width; must match the attached `sdram_bus`.
- Reset is asynchronous and active-low (`rst_n`); the block has a single clock, `clk`.
- `clk`  in  1  system clock, same domain as `sdram`.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; latches `base_addr` and begins a transfer; ignored while `busy`.
- `base_addr`  in  ADDR_BITS  first word address; sampled only on an accepted `start`.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_last`  in  1  qualifies the final byte; meaningful only with `byte_valid`.
- `byte_ready`  out  1  byte accepted on any edge where `byte_valid && byte_ready`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last write is acknowledged.
- `bus`  sdram_bus initiator  —  drives `req`, `we`, `address`, `data_write`; samples `ack`; `data_read` unused.

## Operation
- States: SYNC, IDLE, LOW, HIGH, WRITE.
- SYNC is entered on reset. On the first clock after reset release, set `req <= ack` without starting a transaction, then go to IDLE. A write in flight at reset is lost, and software reloads.
- IDLE: an accepted `start` latches `addr <= base_addr`, sets `busy`, and goes to LOW. Bytes are never accepted in the `start` cycle.
- LOW: `byte_ready` = 1. An accepted byte goes to `data_write[7:0]`.
  - Without `byte_last`, go to HIGH.
  - With `byte_last`, set `data_write[15:8] = 8'h00`, set the last flag, and issue the write.
- HIGH: `byte_ready` = 1. An accepted byte goes to `data_write[15:8]`, and the write is issued. `byte_last` sets the last flag.
- Issuing a write, on the same edge:
  - `we <= 1`
  - `address <= addr`
  - `req <= ~req`
  - go to WRITE.
- WRITE: `byte_ready` = 0, and `we`, `address` and `data_write` are held. Wait until the registered `ack` equals `req`. Then:
  - `addr <= addr + 1`, modulo 2^ADDR_BITS, wrapping from all-ones to 0.
  - If the last flag is set: clear `busy`, pulse `done`, go to IDLE.
  - Otherwise go to LOW.
- At most one outstanding request at any time. `req` toggles only on an issue edge.
- `start` while `busy` is ignored. `byte_valid` in IDLE is ignored, and `byte_ready` stays 0.

## Timing
- Reset values:
  - `byte_ready` = 0, `busy` = 0, `done` = 0
  - `bus.req` = 0, `bus.we` = 0
  - `bus.address` = 0, `bus.data_write` = 0
- After reset release, IDLE is reached 1 cycle later (SYNC).
- `start` at edge N gives `busy` = 1 and `byte_ready` = 1 from N+1.
- The byte completing a word is accepted at edge K. `req` has toggled and `byte_ready` = 0 from K+1.
- `ack == req` is first seen at edge A.
  - Non-final word: `byte_ready` = 1 from A+1, and `address` increments at A.
  - Final word: `done` = 1 and `busy` = 0 during cycle A+1 only.
- Best-case throughput: 2 byte cycles plus the controller write latency per word. Because `ack` is registered, no completion is possible in the issue cycle.
- `bus` outputs are stable for the whole req-toggle-to-ack window.

## Test plan
- Reset: hold `rst_n`=0 with `byte_valid`=1 → all outputs 0; after release, `byte_ready` stays 0 and `req` is unchanged until `start`.
- `start`, base 0x000010, bytes 0x11, 0x22, 0x33, 0x44 (last) → writes addr 0x10 data 0x2211, then addr 0x11 data 0x4433, `we`=1 on both; exactly 2 `req` toggles; one `done` pulse.
- Odd length: base 0x000100, single byte 0xAB with `byte_last` → one write, addr 0x100 data 0x00AB; `done` after the ack.
- Wrap: base 0x7FFFFF, bytes 0x01–0x04 (last on 0x04) → writes 0x7FFFFF/0x0201 and 0x000000/0x0403.
- Backpressure: responder model delays `ack` by 20 cycles, and the source holds `byte_valid`=1 → `byte_ready`=0 for the whole wait; no extra toggles; no byte lost or duplicated.
- `start` pulsed mid-transfer → ignored, with base and address unchanged.
- Reset asserted in WRITE while `ack` is pending, then the responder toggles `ack` → SYNC realigns `req`; the next transfer from base 0x20 completes normally.
